// File: rtl/bin2bcd_arbiter.sv
// bin2bcd_arbiter
//   Lets NREQ requesters share one binary-to-BCD conversion core. Grants are
//   round-robin. Each conversion runs through IDLE -> START -> WAIT -> DONE.
//   If the core never answers, WAIT gives up after TIMEOUT cycles and
//   reports an error result.
// Ports
//   clk, reset   : rising-edge clock and synchronous active-high reset
//   req          : per-requester request levels
//   req_bin      : packed operands; requester i is at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   ack          : one-hot completion pulse to the requester that was served
//   rsp_bcd      : result; valid in the ack cycle and held until the next ack
//   rsp_err      : timeout flag; valid in the ack cycle and held until the next ack
//   busy         : high whenever the FSM is not in IDLE
//   cnv_binary   : operand presented to the core
//   cnv_start    : one-cycle start pulse to the core
//   cnv_bcd      : result from the core
//   cnv_dv       : one-cycle result-valid pulse from the core
module bin2bcd_arbiter #(
  parameter int NREQ           = 4,
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5,
  parameter int TIMEOUT        = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*INPUT_WIDTH-1:0]   req_bin,
  output logic [NREQ-1:0]               ack,
  output logic [DECIMAL_DIGITS*4-1:0]   rsp_bcd,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [INPUT_WIDTH-1:0]        cnv_binary,
  output logic                          cnv_start,
  input  logic [DECIMAL_DIGITS*4-1:0]   cnv_bcd,
  input  logic                          cnv_dv
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last;
  logic [TW-1:0]   tmo_cnt;
  logic [GW-1:0]   pick;
  logic            pick_vld;

  // Round-robin search that starts one past the last requester served. The
  // first hit wins, so the requester just served has the lowest priority.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_vld && req[(int'(last) + k) % NREQ]) begin
        pick     = GW'((int'(last) + k) % NREQ);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last       <= GW'(NREQ - 1);
      tmo_cnt    <= '0;
      ack        <= '0;
      rsp_bcd    <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      cnv_binary <= '0;
      cnv_start  <= 1'b0;
    end else begin
      // ack and cnv_start are single-cycle pulses. Clear them here by
      // default; the case arms below set them when a pulse is due.
      ack       <= '0;
      cnv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant      <= pick;
            cnv_binary <= req_bin[int'(pick)*INPUT_WIDTH +: INPUT_WIDTH];
            cnv_start  <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // A result that arrives on the final allowed cycle still wins
          // over the timeout.
          if (cnv_dv) begin
            rsp_bcd    <= cnv_bcd;
            rsp_err    <= 1'b0;
            ack[grant] <= 1'b1;
            state      <= DONE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            rsp_bcd    <= '0;
            rsp_err    <= 1'b1;
            ack[grant] <= 1'b1;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE: begin
          last  <= grant;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_arbiter.sv
module tb_bin2bcd_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   req_bin;
  logic [NREQ-1:0]     ack;
  logic [19:0]         rsp_bcd;
  logic                rsp_err;
  logic                busy;
  logic [W-1:0]        cnv_binary;
  logic                cnv_start;
  logic [19:0]         cnv_bcd;
  logic                cnv_dv;

  int checks   = 0;
  int failures = 0;
  int model_last;

  bin2bcd_arbiter #(.NREQ(NREQ), .INPUT_WIDTH(W), .DECIMAL_DIGITS(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_bin(req_bin), .ack(ack),
    .rsp_bcd(rsp_bcd), .rsp_err(rsp_err), .busy(busy), .cnv_binary(cnv_binary),
    .cnv_start(cnv_start), .cnv_bcd(cnv_bcd), .cnv_dv(cnv_dv)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Decimal digits, computed by repeated division.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // The first requesting index found after the last one served.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one conversion from IDLE. The core answers lat cycles into WAIT;
  // lat=0 means the core never answers.
  task automatic service(input int lat, input bit ovr, input logic [19:0] ovr_bcd,
                         input bit hold, input bit mutate, input bit early_drop,
                         input bit stale_dv, output logic [NREQ-1:0] ack_seen);
    int g, n;
    bit seen;
    logic [W-1:0] op;
    logic [19:0] exp_bcd;
    g = rr_pick(model_last, req);
    if (g < 0) begin
      $display("FAIL bench: service called with no request");
      $fatal(1, "no request");
    end
    op = req_bin[g*W +: W];
    seen = 1'b0;
    n = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (cnv_start === 1'b1) seen = 1'b1;
    end
    check("start_latency", n, 1);
    check("grant_operand", 32'(cnv_binary), 32'(op));
    check("busy_active", 32'(busy), 1);
    if (stale_dv) begin
      cnv_dv = 1'b1;
      cnv_bcd = 20'hFFFFF;
    end
    if (mutate) req_bin[g*W +: W] = W'($urandom);
    if (early_drop) req[g] = 1'b0;
    exp_bcd = ovr ? ovr_bcd : to_bcd(32'(op));
    for (int c = 1; c <= ((lat > 0) ? lat : TMO); c++) begin
      @(negedge clk);
      cnv_dv = 1'b0;
      check("ack_during_wait", 32'(ack), 0);
      check("start_single", 32'(cnv_start), 0);
    end
    if (lat > 0) begin
      cnv_dv = 1'b1;
      cnv_bcd = exp_bcd;
    end else begin
      exp_bcd = '0;
    end
    @(negedge clk);
    cnv_dv = 1'b0;
    cnv_bcd = 20'($urandom);
    ack_seen = ack;
    check("ack_onehot", 32'(ack), 32'(1) << g);
    check("rsp_bcd", 32'(rsp_bcd), 32'(exp_bcd));
    check("rsp_err", 32'(rsp_err), (lat > 0) ? 0 : 1);
    model_last = g;
    if (!hold) req[g] = 1'b0;
    @(negedge clk);
    check("ack_cleared", 32'(ack), 0);
    check("busy_idle", 32'(busy), 0);
    check("rsp_held", 32'(rsp_bcd), 32'(exp_bcd));
  endtask

  initial begin
    logic [NREQ-1:0] a;
    logic [19:0] exp34 [4];
    int exp35 [8];
    int lat;
    exp34 = '{20'h00000, 20'h00009, 20'h65535, 20'h00100};
    exp35 = '{0, 3, 0, 3, 0, 3, 0, 3};

    reset = 1'b1;
    req = '0;
    req_bin = '0;
    cnv_dv = 1'b0;
    cnv_bcd = '0;
    model_last = NREQ - 1;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(cnv_start), 0);
    check("rst_bcd", 32'(rsp_bcd), 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_binary", 32'(cnv_binary), 0);
    reset = 1'b0;

    // Requester 2, operand 12345, core answers 18 cycles after start
    req_bin[2*W +: W] = 16'd12345;
    req = 4'b0100;
    service(18, 0, '0, 0, 0, 0, 0, a);
    check("req033_ack", 32'(a), 32'h4);
    check("req033_bcd", 32'(rsp_bcd), 32'h12345);

    // Reset again, then all four requesters arrive together
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_last = NREQ - 1;
    req_bin = {16'd100, 16'd65535, 16'd9, 16'd0};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      service(3 + i, 0, '0, 0, 0, 0, 0, a);
      check("req034_ack", 32'(a), 32'(1) << i);
      check("req034_bcd", 32'(rsp_bcd), 32'(exp34[i]));
    end

    // Requesters 0 and 3 request continuously and must be served alternately
    req_bin[0 +: W] = W'($urandom);
    req_bin[3*W +: W] = W'($urandom);
    req = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      service(2 + i, 0, '0, 1, 0, 0, 0, a);
      check("req035_order", 32'(a), 32'(1) << exp35[i]);
    end
    req = '0;
    @(negedge clk);

    // The core never answers (timeout); the next request converts normally
    req_bin[0 +: W] = 16'd777;
    req = 4'b0001;
    service(0, 0, '0, 0, 0, 0, 0, a);
    req_bin[1*W +: W] = 16'd4321;
    req = 4'b0010;
    service(7, 0, '0, 0, 0, 0, 0, a);
    check("after_timeout_bcd", 32'(rsp_bcd), 32'h04321);

    // The result arrives on the final WAIT cycle and still beats the timeout
    req_bin[2*W +: W] = 16'd42;
    req = 4'b0100;
    service(TMO, 1, 20'h00042, 0, 0, 0, 0, a);
    check("req038_bcd", 32'(rsp_bcd), 32'h00042);
    check("req038_err", 32'(rsp_err), 0);

    // Reset in the middle of WAIT, then a stale cnv_dv pulse
    req_bin[2*W +: W] = 16'd555;
    req = 4'b0100;
    @(negedge clk);
    check("rst_mid_start", 32'(cnv_start), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_ack", 32'(ack), 0);
    check("rstmid_bcd", 32'(rsp_bcd), 0);
    check("rstmid_err", 32'(rsp_err), 0);
    check("rstmid_binary", 32'(cnv_binary), 0);
    cnv_dv = 1'b1;
    cnv_bcd = 20'h99999;
    @(negedge clk);
    cnv_dv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stale_dv_ack", 32'(ack), 0);
      check("stale_dv_start", 32'(cnv_start), 0);
      check("stale_dv_busy", 32'(busy), 0);
    end
    model_last = NREQ - 1;
    req_bin[1*W +: W] = 16'd31;
    req_bin[3*W +: W] = 16'd32;
    req = 4'b1010;
    service(4, 0, '0, 0, 0, 0, 0, a);
    check("req037_lowest", 32'(a), 32'h2);
    service(4, 0, '0, 0, 0, 0, 0, a);

    // Random traffic, with operand changes after grant, early drops and stale pulses
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          req_bin[i*W +: W] = W'($urandom);
        end
      end
      if (req == '0) begin
        req[0] = 1'b1;
        req_bin[0 +: W] = W'($urandom);
      end
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      service(lat, 0, '0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin2bcd_arbiter.md
BIN2BCD_ARBITER -- requirements
Module: bin2bcd_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one bin2bcd core.
REQ-002 Parameter INPUT_WIDTH, default 16, binary operand width.
REQ-003 Parameter DECIMAL_DIGITS, default 5, BCD digits returned (result width DECIMAL_DIGITS*4).
REQ-004 Parameter TIMEOUT, default 64, maximum WAIT cycles before aborting a conversion.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  NREQ  per-requester request level, held high until that requester's ack.
REQ-008 req_bin  input  NREQ*INPUT_WIDTH  packed operands; requester i at bits [i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 ack  output  NREQ  one-hot, one-cycle completion pulse to the served requester.
REQ-010 rsp_bcd  output  DECIMAL_DIGITS*4  result, valid in the ack cycle, held until the next ack.
REQ-011 rsp_err  output  1  timeout flag, valid in the ack cycle, held until the next ack.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 cnv_binary  output  INPUT_WIDTH  operand to core, stable from grant until the next grant.
REQ-014 cnv_start  output  1  one-cycle start pulse to core.
REQ-015 cnv_bcd  input  DECIMAL_DIGITS*4  core result.
REQ-016 cnv_dv  input  1  core one-cycle result-valid pulse.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, DONE; all outputs SHALL be registered.
REQ-018 IDLE: if any req bit is high, grant the first set bit searching round-robin from (last+1) mod NREQ, latch req_bin slice into cnv_binary, go to START; otherwise stay.
REQ-019 START: cnv_start SHALL be 1 for exactly this cycle; clear timeout counter; go to WAIT.
REQ-020 WAIT: on cnv_dv=1 capture cnv_bcd into rsp_bcd, rsp_err=0, go to DONE.
REQ-021 WAIT: after TIMEOUT consecutive WAIT cycles without cnv_dv, set rsp_bcd=0, rsp_err=1, go to DONE.
REQ-022 If cnv_dv and the timeout coincide, cnv_dv SHALL win (result captured, rsp_err=0).
REQ-023 DONE: ack[grant]=1 for this cycle only; last=grant; go to IDLE.
REQ-024 Latency: req seen in IDLE cycle n -> cnv_start in n+1; cnv_dv in cycle m -> ack in m+1.
REQ-025 Requester SHALL deassert req on the clock edge where its ack is high; req is sampled only in IDLE.
REQ-026 req_bin changes after grant SHALL NOT affect the running conversion.
REQ-027 A granted requester dropping req before ack SHALL still receive its ack pulse; result unchanged.
REQ-028 cnv_dv outside WAIT SHALL be ignored.
REQ-029 At most one ack bit SHALL be high in any cycle; cnv_start SHALL never be high outside START.
REQ-030 Two continuously requesting requesters SHALL be served alternately (no starvation).

Reset
REQ-031 reset=1 at any edge, including mid-conversion, SHALL force IDLE next cycle with ack=0, cnv_start=0, busy=0, rsp_bcd=0, rsp_err=0, cnv_binary=0, timeout counter=0.
REQ-032 After reset last=NREQ-1, so requester 0 has highest priority first.

Verification
REQ-033 req[2]=1, operand 16'd12345, core model dv after 18 cycles -> ack=4'b0100, rsp_bcd=20'h12345, rsp_err=0.
REQ-034 After reset, all four req with operands 0, 9, 65535, 100 -> acks in order 0,1,2,3 with rsp_bcd 20'h00000, 20'h00009, 20'h65535, 20'h00100.
REQ-035 req0 and req3 held high for eight services -> ack order 0,3,0,3,0,3,0,3.
REQ-036 Core never asserts cnv_dv -> ack one cycle after 64 WAIT cycles, rsp_bcd=0, rsp_err=1; next request then converts correctly.
REQ-037 Reset asserted during WAIT, stale cnv_dv pulse afterward -> busy=0, no ack, no cnv_start; next grant goes to lowest-index requester.
REQ-038 cnv_dv pulsed on the 64th WAIT cycle with cnv_bcd=20'h00042 -> rsp_bcd=20'h00042, rsp_err=0.
